// File: rtl/gray_pkg.sv
// Shared types and gray-code helpers for the gray pointer reader.
// Helpers work on GW-bit vectors; callers zero-extend and truncate to their own width.
package gray_pkg;

  typedef enum logic [1:0] {SYNC, RUN, ERR} state_t;

  localparam int GW = 32;

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when a and b differ in zero or exactly one bit position.
  function automatic logic at_most_one_bit(input logic [GW-1:0] a, input logic [GW-1:0] b);
    logic [GW-1:0] d;
    d = a ^ b;
    return (d & (d - 1'b1)) == '0;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a gray-coded bus; STAGES cycles of latency, no flow control.
module gray_sync #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_reader.sv
// Read side of an async pointer pair: syncs the writer's gray count, offers tokens valid/ready,
// returns a glitch-free gray read count; write changes show up SYNC_STAGES+1 edges later.
module gray_ptr_reader
  import gray_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] wr_ptr_gray_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] avail_o,
  output logic [N-1:0] rd_ptr_gray_o,
  output logic         err_o
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [N-1:0]  sync_gray;
  logic [N-1:0]  prev_gray_q;
  logic [N-1:0]  wr_bin_q;
  logic [N-1:0]  rd_bin_q;
  logic [N-1:0]  rd_next;
  logic [N-1:0]  avail;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic          xfer;
  logic          step_ok;

  gray_sync #(
    .N      (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (wr_ptr_gray_i),
    .q_o   (sync_gray)
  );

  assign avail   = wr_bin_q - rd_bin_q;
  assign avail_o = avail;
  assign valid_o = (state_q == RUN) && (avail != '0);
  assign xfer    = valid_o && ready_i;
  assign rd_next = rd_bin_q + N'(xfer);
  assign step_ok = at_most_one_bit(GW'(sync_gray), GW'(prev_gray_q));
  assign err_o   = (state_q == ERR);

  // The gray output is computed from rd_next so it is a clean flop, never a decoded glitch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_gray_q   <= '0;
      wr_bin_q      <= '0;
      rd_bin_q      <= '0;
      rd_ptr_gray_o <= '0;
    end else begin
      prev_gray_q   <= sync_gray;
      wr_bin_q      <= N'(gray2bin(GW'(sync_gray)));
      rd_bin_q      <= rd_next;
      rd_ptr_gray_o <= N'(bin2gray(GW'(rd_next)));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SYNC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // SYNC holds off checking until the chain is flushed of reset zeros.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SYNC: begin
        if (cnt_q == CW'(SYNC_STAGES)) state_d = RUN;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      RUN: begin
        if (!step_ok) state_d = ERR;
      end
      ERR:     state_d = ERR;
      default: state_d = SYNC;
    endcase
  end

endmodule

// File: tb/tb_gray_ptr_reader.sv
// Directed bench for gray_ptr_reader with N=8, SYNC_STAGES=2.
module tb_gray_ptr_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] wr_gray = 8'h00;
  logic       valid;
  logic       err;
  logic [7:0] avail;
  logic [7:0] rd_gray;

  int total = 0;
  int bad   = 0;

  gray_ptr_reader #(
    .N           (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_ptr_gray_i (wr_gray),
    .valid_o       (valid),
    .ready_i       (ready),
    .avail_o       (avail),
    .rd_ptr_gray_o (rd_gray),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #2 rst = 1'b1;
    tick(2);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_avail", 32'(avail), 32'h0);
    chk("rst_rdgray", 32'(rd_gray), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick(4);
    chk("idle_valid", 32'(valid), 32'h0);
    chk("idle_err", 32'(err), 32'h0);

    // single write step, no consumer: visible exactly 3 edges later and held
    wr_gray = 8'h01;
    tick(1);
    chk("lat_e1_valid", 32'(valid), 32'h0);
    tick(1);
    chk("lat_e2_valid", 32'(valid), 32'h0);
    tick(1);
    chk("lat_e3_avail", 32'(avail), 32'h1);
    chk("lat_e3_valid", 32'(valid), 32'h1);
    tick(2);
    chk("hold_valid", 32'(valid), 32'h1);
    chk("hold_avail", 32'(avail), 32'h1);

    // stepped writes with consumer always ready
    ready = 1'b1;
    tick(1);
    chk("step01_rd", 32'(rd_gray), 32'h01);
    chk("step01_avail", 32'(avail), 32'h0);
    wr_gray = 8'h03; tick(4);
    chk("step03_rd", 32'(rd_gray), 32'h03);
    wr_gray = 8'h02; tick(4);
    chk("step02_rd", 32'(rd_gray), 32'h02);
    wr_gray = 8'h06; tick(4);
    chk("step06_rd", 32'(rd_gray), 32'h06);
    wr_gray = 8'h07; tick(4);
    chk("step07_rd", 32'(rd_gray), 32'h07);
    chk("step_end_avail", 32'(avail), 32'h0);
    chk("step_end_valid", 32'(valid), 32'h0);
    chk("step_end_err", 32'(err), 32'h0);

    // transfer coinciding with a write update (wr 5->6->7, rd 5->6)
    ready = 1'b0;
    wr_gray = 8'h05; tick(3);
    chk("coin_pre_avail", 32'(avail), 32'h1);
    chk("coin_pre_valid", 32'(valid), 32'h1);
    wr_gray = 8'h04; tick(2);
    chk("coin_wait_avail", 32'(avail), 32'h1);
    ready = 1'b1;
    tick(1);
    chk("coin_avail", 32'(avail), 32'h1);
    chk("coin_valid", 32'(valid), 32'h1);
    chk("coin_rd", 32'(rd_gray), 32'h05);

    // walk both pointers up to 254, then wrap
    for (int b = 8; b <= 254; b++) begin
      wr_gray = 8'(b ^ (b >> 1));
      tick(1);
    end
    tick(6);
    chk("walk_rd", 32'(rd_gray), 32'h81);
    chk("walk_avail", 32'(avail), 32'h0);
    chk("walk_err", 32'(err), 32'h0);
    ready = 1'b0;
    wr_gray = 8'h80; tick(1);
    wr_gray = 8'h00; tick(1);
    wr_gray = 8'h01; tick(1);
    wr_gray = 8'h03; tick(4);
    chk("wrap_avail", 32'(avail), 32'h4);
    chk("wrap_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    tick(1);
    chk("wrap_rd0", 32'(rd_gray), 32'h80);
    tick(1);
    chk("wrap_rd1", 32'(rd_gray), 32'h00);
    tick(1);
    chk("wrap_rd2", 32'(rd_gray), 32'h01);
    tick(1);
    chk("wrap_rd3", 32'(rd_gray), 32'h03);
    chk("wrap_end_avail", 32'(avail), 32'h0);
    chk("wrap_end_valid", 32'(valid), 32'h0);
    tick(2);
    chk("idle_ready_rd", 32'(rd_gray), 32'h03);

    // reset asserted mid-stream with a transfer pending
    ready = 1'b0;
    wr_gray = 8'h02; tick(3);
    chk("pre_rst_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_avail", 32'(avail), 32'h0);
    chk("mid_rst_rd", 32'(rd_gray), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    ready = 1'b0;
    wr_gray = 8'h07;
    tick(1);
    rst = 1'b0;
    chk("rel_c0_valid", 32'(valid), 32'h0);
    tick(1);
    chk("rel_c1_valid", 32'(valid), 32'h0);
    tick(1);
    chk("rel_c2_valid", 32'(valid), 32'h0);
    tick(1);
    chk("rel_run_valid", 32'(valid), 32'h1);
    chk("rel_run_avail", 32'(avail), 32'h5);
    chk("rel_run_rd", 32'(rd_gray), 32'h0);

    // two-bit jump in RUN trips the sticky error
    rst = 1'b1;
    wr_gray = 8'h00;
    tick(1);
    rst = 1'b0;
    tick(4);
    chk("pre_err_valid", 32'(valid), 32'h0);
    chk("pre_err_err", 32'(err), 32'h0);
    wr_gray = 8'h03;
    tick(2);
    chk("jump_e2_err", 32'(err), 32'h0);
    tick(1);
    chk("jump_e3_err", 32'(err), 32'h1);
    chk("jump_e3_valid", 32'(valid), 32'h0);
    ready = 1'b1;
    wr_gray = 8'h02;
    tick(5);
    chk("err_sticky", 32'(err), 32'h1);
    chk("err_valid", 32'(valid), 32'h0);
    chk("err_rd_frozen", 32'(rd_gray), 32'h0);
    rst = 1'b1;
    #1;
    chk("err_clear", 32'(err), 32'h0);
    rst = 1'b0;
    ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_ptr_reader.md
GRAY_PTR_READER -- requirements
Module: gray_ptr_reader

Interface
REQ-001 SHALL have parameter N, default 8: pointer width; counts are modulo 2^N.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth, minimum 2.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_i  input  1  sole clock; all flops on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 wr_ptr_gray_i  input  N  gray-coded free-running write count; asynchronous to clk_i.
REQ-007 valid_o  output  1  at least one unconsumed token is available.
REQ-008 ready_i  input  1  consumer accepts a token.
REQ-009 avail_o  output  N  unconsumed token count, (wr_bin - rd_bin) mod 2^N.
REQ-010 rd_ptr_gray_o  output  N  registered, gray-coded read count, returned to the writer.
REQ-011 err_o  output  1  sticky protocol error.

Function
REQ-012 wr_ptr_gray_i SHALL pass through a SYNC_STAGES flop chain and then be decoded to binary into register wr_bin_q.
REQ-013 A change on wr_ptr_gray_i SHALL appear on avail_o/valid_o exactly SYNC_STAGES+1 rising edges later.
REQ-014 avail_o SHALL equal (wr_bin_q - rd_bin_q) mod 2^N, combinationally from registers.
REQ-015 valid_o SHALL be 1 iff state==RUN and avail_o != 0.
REQ-016 Transfer SHALL occur when valid_o && ready_i; rd_bin_q then increments by 1 at the next edge.
REQ-017 rd_bin_q SHALL wrap from 2^N-1 to 0.
REQ-018 rd_ptr_gray_o SHALL be a flop loaded with bin2gray(next rd_bin_q), so it changes by exactly one bit per transfer and never glitches.
REQ-019 When a transfer and a wr_bin_q update coincide, next avail SHALL equal new_wr - (rd+1) mod 2^N.
REQ-020 Once valid_o is high, it SHALL stay high until a transfer occurs, except on entry to ERR.
REQ-021 ready_i while valid_o=0 SHALL have no effect.
REQ-022 FSM states SHALL be SYNC, RUN and ERR.
REQ-023 After reset release, the FSM SHALL stay in SYNC for SYNC_STAGES+1 cycles, then enter RUN.
REQ-024 In RUN, if consecutive synchronizer outputs differ in more than one bit, the FSM SHALL enter ERR.
REQ-025 The error SHALL be visible on err_o at the same edge the offending value reaches wr_bin_q.
REQ-026 Error detection SHALL be disabled in SYNC.
REQ-027 In ERR: err_o=1, valid_o=0, rd_bin_q frozen, ready_i ignored; leaves ERR only via rst_i.
REQ-028 Full 2^N outstanding tokens is indistinguishable from empty; the writer SHALL never exceed 2^N-1 outstanding tokens.

Reset
REQ-029 rst_i SHALL asynchronously clear the synchronizer, wr_bin_q, rd_bin_q, rd_ptr_gray_o, the previous-sample register and the SYNC counter.
REQ-030 rst_i SHALL put the FSM in SYNC.
REQ-031 During and right after reset: valid_o=0, avail_o=0, rd_ptr_gray_o=0, err_o=0.
REQ-032 Reset asserted mid-transfer SHALL discard the transfer with no partial update.

Structure
REQ-033 Package gray_pkg SHALL hold the state enum typedef (SYNC, RUN, ERR) and the bin2gray/gray2bin functions.
REQ-034 Package gray_pkg SHALL also hold the one-hot-change check function.
REQ-035 Sub-module gray_sync SHALL implement the N-bit, SYNC_STAGES-deep synchronizer chain with reset to 0.

Verification (N=8, SYNC_STAGES=2)
REQ-036 Assert rst_i mid-stream -> all outputs 0 immediately; after release valid_o=0 for 3 cycles even with wr_ptr_gray_i=8'h07.
REQ-037 In RUN, wr_ptr_gray_i 00->01, ready_i=0 -> avail_o=1, valid_o=1 exactly 3 edges later, and held.
REQ-038 wr_ptr_gray_i stepped 01,03,02,06,07 with ready_i=1 -> 5 transfers; rd_ptr_gray_o 01,03,02,06,07; avail_o ends 0.
REQ-039 rd=254 (rd_ptr_gray_o=8'h81), wr advanced to 2 (gray 8'h03) -> avail_o=4; transfers give rd_ptr_gray_o 80,00,01,03.
REQ-040 In RUN, wr_ptr_gray_i jumps 00->03 -> err_o=1 and valid_o=0 3 edges later; err_o stays 1 until rst_i.
REQ-041 avail_o=1, transfer in the same cycle wr_bin_q goes +1 -> avail_o stays 1 and valid_o stays high.
